// File: rtl/id_stage_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, bus field offsets
// and instruction field offsets used by the decode stage.
package id_stage_pkg;

    // IF -> ID bus: {pc[31:0], inst[31:0]}
    localparam int FS_TO_DS_BUS_W = 64;
    localparam int FS_INST_LSB    = 0;
    localparam int FS_PC_LSB      = 32;

    // ID -> EXE bus: {pc[31:0], src1[31:0], src2[31:0], rf_waddr[4:0]}
    localparam int DS_TO_ES_BUS_W = 101;
    localparam int DS_WADDR_LSB   = 0;
    localparam int DS_SRC2_LSB    = 5;
    localparam int DS_SRC1_LSB    = 37;
    localparam int DS_PC_LSB      = 69;

    // Register specifier fields inside the instruction word
    localparam int INST_RD_LSB    = 0;
    localparam int INST_RJ_LSB    = 5;
    localparam int INST_RK_LSB    = 10;
    localparam int REG_IDX_W      = 5;

endpackage

// File: rtl/ds_perf_counter.sv
// Saturating 32-bit event counter; cleared only by reset, sticks at all-ones.
module ds_perf_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: add one per event unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_stage.sv
// Decode stage: holds one instruction from IF, stalls on load-use / CSR
// hazards, and hands EXE the pc plus forwarded operands with zero latency.
// Handshake: a stage transfers on a cycle where the producer's valid and the
// consumer's allowin are both high; valid never depends on allowin.
module id_stage #(
    parameter int FS_TO_DS_BUS_W = id_stage_pkg::FS_TO_DS_BUS_W,
    parameter int DS_TO_ES_BUS_W = id_stage_pkg::DS_TO_ES_BUS_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
    output logic                      ds_allowin,
    input  logic                      es_allowin,
    output logic                      ds_to_es_valid,
    output logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus,
    output logic [4:0]                rf_raddr1,
    output logic [4:0]                rf_raddr2,
    input  logic [31:0]               rf_rdata1_bypassing,
    input  logic [31:0]               rf_rdata2_bypassing,
    input  logic                      Load_DataHazard,
    input  logic                      CSR_DataHazard,
    input  logic                      wb_flush,
    output logic [31:0]               stall_cnt
);

    import id_stage_pkg::*;

    logic                      ds_valid_q;
    logic                      ds_valid_d;
    logic [FS_TO_DS_BUS_W-1:0] fs_bus_q;
    logic [FS_TO_DS_BUS_W-1:0] fs_bus_d;

    logic        ds_stall;
    logic        ds_ready_go;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        unused_inst_bits;

    assign ds_pc   = fs_bus_q[FS_PC_LSB +: 32];
    assign ds_inst = fs_bus_q[FS_INST_LSB +: 32];
    assign unused_inst_bits = &{1'b0, ds_inst[31:15]};

    // Hazard stall and pipeline handshake, all combinational
    always_comb begin
        ds_stall       = ds_valid_q & (Load_DataHazard | CSR_DataHazard);
        ds_ready_go    = ~ds_stall;
        ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
        ds_to_es_valid = ds_valid_q & ds_ready_go & ~wb_flush;
    end

    // Next valid / held bus: flush wins, otherwise refill when allowed
    always_comb begin
        ds_valid_d = ds_valid_q;
        fs_bus_d   = fs_bus_q;
        if (wb_flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end
        if (fs_to_ds_valid && ds_allowin && !wb_flush) begin
            fs_bus_d = fs_to_ds_bus;
        end
    end

    // Stage registers, cleared by reset so a stalled instruction is discarded
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q <= 1'b0;
            fs_bus_q   <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            fs_bus_q   <= fs_bus_d;
        end
    end

    // Outgoing bus: operands come straight from the bypass network
    always_comb begin
        ds_to_es_bus = '0;
        ds_to_es_bus[DS_PC_LSB    +: 32]        = ds_pc;
        ds_to_es_bus[DS_SRC1_LSB  +: 32]        = rf_rdata1_bypassing;
        ds_to_es_bus[DS_SRC2_LSB  +: 32]        = rf_rdata2_bypassing;
        ds_to_es_bus[DS_WADDR_LSB +: REG_IDX_W] = ds_inst[INST_RD_LSB +: REG_IDX_W];
    end

    assign rf_raddr1 = ds_inst[INST_RJ_LSB +: REG_IDX_W];
    assign rf_raddr2 = ds_inst[INST_RK_LSB +: REG_IDX_W];

    // Cycles lost to hazards; a flushed cycle is not counted
    ds_perf_counter u_perf (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ds_stall & ~wb_flush),
        .cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed pipeline scenarios, scoreboard of expected
// ID->EXE bus words, popped whenever EXE accepts an instruction.
module tb_id_stage;

    logic         clk;
    logic         resetn;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [100:0] ds_to_es_bus;
    logic [4:0]   rf_raddr1;
    logic [4:0]   rf_raddr2;
    logic [31:0]  rf_rdata1_bypassing;
    logic [31:0]  rf_rdata2_bypassing;
    logic         Load_DataHazard;
    logic         CSR_DataHazard;
    logic         wb_flush;
    logic [31:0]  stall_cnt;

    logic [100:0] exp_q[$];
    logic [100:0] mon_exp;
    int           n_checks;
    int           n_errors;
    logic [31:0]  insts[0:15];

    id_stage u_dut (
        .clk                 (clk),
        .resetn              (resetn),
        .fs_to_ds_valid      (fs_to_ds_valid),
        .fs_to_ds_bus        (fs_to_ds_bus),
        .ds_allowin          (ds_allowin),
        .es_allowin          (es_allowin),
        .ds_to_es_valid      (ds_to_es_valid),
        .ds_to_es_bus        (ds_to_es_bus),
        .rf_raddr1           (rf_raddr1),
        .rf_raddr2           (rf_raddr2),
        .rf_rdata1_bypassing (rf_rdata1_bypassing),
        .rf_rdata2_bypassing (rf_rdata2_bypassing),
        .Load_DataHazard     (Load_DataHazard),
        .CSR_DataHazard      (CSR_DataHazard),
        .wb_flush            (wb_flush),
        .stall_cnt           (stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [100:0] exp_bus(input logic [31:0] pc, input logic [31:0] inst);
        return {pc, rf_rdata1_bypassing, rf_rdata2_bypassing, inst[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
    endtask

    // Scoreboard: every accepted emission must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && ds_to_es_valid && es_allowin) begin
            if (exp_q.size() == 0) begin
                check("unexpected_emit", ds_to_es_bus, 128'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("emit_bus", ds_to_es_bus, mon_exp);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b1;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus = 64'h0;
        es_allowin = 1'b1;
        Load_DataHazard = 1'b0;
        CSR_DataHazard = 1'b0;
        wb_flush = 1'b0;
        rf_rdata1_bypassing = $urandom();
        rf_rdata2_bypassing = $urandom();
        for (int i = 0; i < 16; i++) insts[i] = $urandom_range(32'hFFFF_FFFF, 0);

        // Reset
        #2 resetn = 1'b0;
        tick();
        tick();
        mid();
        check("rst_valid", ds_to_es_valid, 1'b0);
        check("rst_allowin", ds_allowin, 1'b1);
        check("rst_raddr1", rf_raddr1, 5'd0);
        check("rst_raddr2", rf_raddr2, 5'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_bus_pc", ds_to_es_bus[100:69], 32'd0);
        tick();
        resetn = 1'b1;

        // Streaming: four back-to-back instructions, one-cycle latency
        for (int k = 0; k < 4; k++) begin
            tick();
            send(32'h1C00_0000 + 32'(4 * k), insts[k]);
            exp_q.push_back(exp_bus(32'h1C00_0000 + 32'(4 * k), insts[k]));
            mid();
            check("stream_allowin", ds_allowin, 1'b1);
            if (k > 0) begin
                check("stream_valid", ds_to_es_valid, 1'b1);
                check("stream_raddr1", rf_raddr1, insts[k-1][9:5]);
                check("stream_raddr2", rf_raddr2, insts[k-1][14:10]);
            end
        end
        tick();
        fs_to_ds_valid = 1'b0;
        mid();
        check("stream_last_valid", ds_to_es_valid, 1'b1);
        check("stream_last_raddr1", rf_raddr1, insts[3][9:5]);
        tick();
        mid();
        check("stream_idle_valid", ds_to_es_valid, 1'b0);

        // Load-use stall for two cycles; IF keeps offering the next one
        tick();
        send(32'h1C00_0010, insts[4]);
        exp_q.push_back(exp_bus(32'h1C00_0010, insts[4]));
        mid();
        tick();
        send(32'h1C00_0014, insts[5]);
        Load_DataHazard = 1'b1;
        for (int j = 0; j < 2; j++) begin
            mid();
            check("load_allowin", ds_allowin, 1'b0);
            check("load_valid", ds_to_es_valid, 1'b0);
            check("load_bus_pc", ds_to_es_bus[100:69], 32'h1C00_0010);
            tick();
        end
        Load_DataHazard = 1'b0;
        exp_q.push_back(exp_bus(32'h1C00_0014, insts[5]));
        mid();
        check("load_release_valid", ds_to_es_valid, 1'b1);
        check("load_stall_cnt", stall_cnt, 32'd2);
        check("load_release_allowin", ds_allowin, 1'b1);
        tick();
        fs_to_ds_valid = 1'b0;
        mid();
        check("load_next_valid", ds_to_es_valid, 1'b1);
        check("load_next_pc", ds_to_es_bus[100:69], 32'h1C00_0014);

        // Back-pressure from EXE for three cycles
        tick();
        send(32'h1C00_0018, insts[6]);
        exp_q.push_back(exp_bus(32'h1C00_0018, insts[6]));
        tick();
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mid();
            check("bp_valid", ds_to_es_valid, 1'b1);
            check("bp_allowin", ds_allowin, 1'b0);
            check("bp_bus_pc", ds_to_es_bus[100:69], 32'h1C00_0018);
            check("bp_stall_cnt", stall_cnt, 32'd2);
            tick();
        end
        es_allowin = 1'b1;
        mid();
        check("bp_release_valid", ds_to_es_valid, 1'b1);
        tick();
        mid();
        check("bp_after_valid", ds_to_es_valid, 1'b0);

        // Flush during a CSR stall, with IF offering a new instruction
        tick();
        send(32'h1C00_001C, insts[7]);
        mid();
        tick();
        CSR_DataHazard = 1'b1;
        send(32'h1C00_0020, insts[8]);
        mid();
        check("csr_valid", ds_to_es_valid, 1'b0);
        check("csr_allowin", ds_allowin, 1'b0);
        check("csr_stall_cnt_pre", stall_cnt, 32'd2);
        tick();
        wb_flush = 1'b1;
        mid();
        check("flush_valid", ds_to_es_valid, 1'b0);
        check("flush_stall_cnt", stall_cnt, 32'd3);
        tick();
        wb_flush = 1'b0;
        CSR_DataHazard = 1'b0;
        fs_to_ds_valid = 1'b0;
        mid();
        check("post_flush_valid", ds_to_es_valid, 1'b0);
        check("post_flush_allowin", ds_allowin, 1'b1);
        check("post_flush_stall_cnt", stall_cnt, 32'd3);
        check("post_flush_raddr1", rf_raddr1, insts[7][9:5]);

        // Flush concurrent with an incoming instruction into an empty stage
        tick();
        send(32'h1C00_0024, insts[9]);
        wb_flush = 1'b1;
        mid();
        check("flush_in_allowin", ds_allowin, 1'b1);
        tick();
        wb_flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        mid();
        check("flush_in_dropped", ds_to_es_valid, 1'b0);
        check("flush_in_raddr2", rf_raddr2, insts[7][14:10]);

        // Saturation: counter preset to 0xFFFFFFFE, then three stall cycles
        tick();
        send(32'h1C00_0028, insts[10]);
        exp_q.push_back(exp_bus(32'h1C00_0028, insts[10]));
        tick();
        fs_to_ds_valid = 1'b0;
        Load_DataHazard = 1'b1;
        #1 force u_dut.u_perf.cnt_q = 32'hFFFF_FFFE;
        #1 release u_dut.u_perf.cnt_q;
        tick();
        mid();
        check("sat_cnt_1", stall_cnt, 32'hFFFF_FFFF);
        check("sat_valid", ds_to_es_valid, 1'b0);
        tick();
        mid();
        check("sat_cnt_2", stall_cnt, 32'hFFFF_FFFF);
        tick();
        Load_DataHazard = 1'b0;
        mid();
        check("sat_cnt_3", stall_cnt, 32'hFFFF_FFFF);
        check("sat_release_valid", ds_to_es_valid, 1'b1);

        // Asynchronous reset asserted off-edge in the middle of a stall
        tick();
        send(32'h1C00_002C, insts[11]);
        mid();
        tick();
        fs_to_ds_valid = 1'b0;
        CSR_DataHazard = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", ds_to_es_valid, 1'b0);
        check("arst_allowin", ds_allowin, 1'b1);
        check("arst_raddr1", rf_raddr1, 5'd0);
        check("arst_raddr2", rf_raddr2, 5'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        check("arst_bus_pc", ds_to_es_bus[100:69], 32'd0);
        tick();
        #2 resetn = 1'b1;
        CSR_DataHazard = 1'b0;
        send(32'h1C00_0030, insts[12]);
        exp_q.push_back(exp_bus(32'h1C00_0030, insts[12]));
        #1;
        check("post_rst_allowin", ds_allowin, 1'b1);
        tick();
        fs_to_ds_valid = 1'b0;
        mid();
        check("post_rst_valid", ds_to_es_valid, 1'b1);
        check("post_rst_raddr1", rf_raddr1, insts[12][9:5]);

        // Drain and confirm every expected emission was seen
        tick();
        tick();
        tick();
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
